keccak_string_to_state: RTL
===========================

Name: keccak_string_to_state

Overview:
- Inverse of the Keccak state-to-string conversion.
- Takes a 1600-bit Keccak string as a stream of 25 × 64-bit words, lowest string bits first.
- Rebuilds the 5×5×64 state array A[x][y][z] and presents it as one registered x-major state word to the permutation core.
- Sits between the message/padding front-end and the Keccak-f[1600] round logic.
- A short final message (in_last before word 24) is zero-filled to 1600 bits.

Parameters:
- LANE_W, 64, lane width w in bits. Only 64 is supported; must equal the input word width.
- NLANES, 25, number of lanes (5×5). Fixed.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  64  string word k, carrying string bits S[64k+63:64k]; bit z = S[64k+z].
- in_last  input  1  this word is the final word of the string.
- out_valid  output  1  state_o holds a complete state.
- out_ready  input  1  consumer accepts state_o.
- state_o  output  1600  state, x-major: state_o[64*(5x+y)+z] = A[x][y][z].
- lane_cnt_o  output  5  number of words accepted in the current string, 0..25.

Behaviour:
- Reset (reset=0, async) sets:
  - FSM=IDLE, word counter k=0, internal x=0, y=0.
  - All 25 lane registers = 0, state_o=0.
  - in_ready=0 while reset is asserted, then 1 in IDLE.
  - out_valid=0, lane_cnt_o=0.
- Mapping for accepted word k:
  - x = k mod 5, y = k div 5.
  - Lane[x][y] <= in_data, so A[x][y][z] = S[64(5y+x)+z].
  - x/y are kept as separate wrap counters (x 0..4; y increments when x wraps). No divider.
- Accept condition: in_valid && in_ready on a rising edge.
- FSM states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On accept: all lanes except lane[0][0] are cleared, lane[0][0] <= in_data, k=1, x=1, y=0.
    - Next state is HOLD if in_last, else FILL.
    - lane_cnt_o=1.
  - FILL:
    - in_ready=1.
    - On accept: lane[x][y] <= in_data, k increments, x/y advance.
    - Next state is HOLD if in_last or if this was word 24 (k becomes 25); otherwise stay in FILL.
    - If in_last arrives at word 24, the result is identical to word 24 alone.
  - HOLD:
    - in_ready=0, out_valid=1.
    - state_o and lane_cnt_o are stable.
    - On out_valid && out_ready, next state is IDLE; k, x, y reset to 0.
    - Lanes are not cleared on exit. They are cleared only when the next string's first word is accepted, so state_o retains the last state.
- Latency and throughput:
  - out_valid rises on the cycle after the final word is accepted.
  - Minimum cycle per full string is 25 accept cycles + 1 HOLD cycle with out_ready=1 + the next IDLE accept = 26 cycles/string.
- Zero fill: lanes with index ≥ k at the in_last word read 0 in state_o.
- Simultaneous events:
  - In HOLD, an in_valid that arrives together with out_ready is not accepted, because in_ready=0 that cycle. It is accepted no earlier than the following IDLE cycle.
  - in_valid=0 in FILL: the block stalls indefinitely and keeps all state.
- Input stability: in_data/in_last may change freely while in_valid=0. They are sampled only on accept.
- Reset mid-operation: any state returns immediately to the reset values. A partial string is discarded and out_valid drops asynchronously.
- state_o and lane_cnt_o are registered outputs; no combinational path from inputs.

Test Plan:
- Reset then 25 words, in_data = {32'hA5A5_0000 | k} for k=0..24, in_last on k=24, out_ready=1:
  - state_o[64*(5x+y) +: 64] == word (5y+x) for all x,y; e.g. lane x=1,y=0 == word 1, lane x=0,y=1 == word 5.
  - out_valid exactly 1 cycle after the last accept; lane_cnt_o=25.
- Short string: 3 words 64'h1, 64'h2, 64'h3 with in_last on word 3:
  - Lanes (0,0)=1, (1,0)=2, (2,0)=3, all other 1408 bits 0.
  - lane_cnt_o=3; in_ready=0 in HOLD.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD, drive in_valid=1:
  - No word accepted, state_o unchanged, out_valid stays 1.
  - Accept resumes the cycle after out_ready=1.
- Bit mapping: single word 64'h8000_0000_0000_0001 at k=7 (x=2, y=1), preceded by zeros:
  - state_o bit 64*11+0 = 1 and bit 64*11+63 = 1; no other bits set.
- Stalls: random in_valid gaps (≈50%) over 3 back-to-back full strings:
  - Each output matches the reference model.
  - Second string fully overwrites the first; no lanes from the previous string leak into the second.
- Async reset asserted after word 12 of a string:
  - out_valid=0, lane_cnt_o=0, state_o=0 immediately.
  - The next full string produces the correct state.

Source files
------------

// File: rtl/keccak_string_to_state.sv
// Rebuilds the 5x5x64 Keccak state from a stream of 25 64-bit string words,
// lowest string bits first, zero-filling short strings.
module keccak_string_to_state #(
    parameter int LANE_W = 64,
    parameter int NLANES = 25
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANE_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANE_W*NLANES-1:0]   state_o,
    output logic [4:0]                 lane_cnt_o
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t            state, state_nxt;
    logic [LANE_W-1:0] lanes [NLANES];
    logic [4:0]        k;
    logic [2:0]        x, y;
    logic [4:0]        wr_idx;
    logic              accept;

    assign accept = in_valid && in_ready;
    // Lane storage is x-major: index 5x+y, computed without a multiplier.
    assign wr_idx = {x, 2'b00} + {2'b00, x} + {2'b00, y};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_last ? HOLD : FILL;
                end
            end
            FILL: begin
                if (accept && (in_last || k == 5'd24)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, FILL: in_ready  = reset;
            HOLD:       out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                lanes[i] <= '0;
            end
            k <= '0;
            x <= '0;
            y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Previous string's lanes are cleared only here, so the
                        // last state stays visible while idle.
                        for (int unsigned i = 0; i < NLANES; i++) begin
                            lanes[i] <= (i == 0) ? in_data : '0;
                        end
                        k <= 5'd1;
                        x <= 3'd1;
                        y <= 3'd0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        lanes[wr_idx] <= in_data;
                        k <= k + 5'd1;
                        if (x == 3'd4) begin
                            x <= '0;
                            y <= y + 3'd1;
                        end else begin
                            x <= x + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        k <= '0;
                        x <= '0;
                        y <= '0;
                    end
                end
                default: begin
                    k <= '0;
                    x <= '0;
                    y <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_o = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            state_o[LANE_W*i +: LANE_W] = lanes[i];
        end
    end

    assign lane_cnt_o = k;

endmodule
